// File: rtl/key_pkg.sv
// Shared key-path definitions: key count, code width and one-hot helpers.
package key_pkg;

    localparam int unsigned KEY_W  = 4;
    localparam int unsigned CODE_W = $clog2(KEY_W);

    // Bit index of the single set bit; zero when no bit is set.
    function automatic logic [CODE_W-1:0] onehot_to_code(input logic [KEY_W-1:0] k);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = 0; i < int'(KEY_W); i++) begin
            if (k[i]) begin
                code = code | CODE_W'(i);
            end
        end
        return code;
    endfunction

    // True when exactly one bit of k is set.
    function automatic logic is_onehot(input logic [KEY_W-1:0] k);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < int'(KEY_W); i++) begin
            ones = ones + 32'(k[i]);
        end
        return ones == 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO, first-word-fall-through, with occupancy count.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = CNT_W'(count + 1'b1);
        end else if (do_pop && !do_push) begin
            count_nxt = CNT_W'(count - 1'b1);
        end
    end

    // Pointers, count and registered full/empty flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            end
            if (do_pop) begin
                rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage; cleared on reset so the head output reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Encodes one-hot key pulses into codes and queues them for a valid/ready consumer.
// Multi-hot input is rejected and flagged; drops on a full queue set a sticky overflow.
module key_event_queue #(
    parameter int unsigned KEY_W = key_pkg::KEY_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [KEY_W-1:0]           key_val,
    output logic                       evt_valid,
    output logic [$clog2(KEY_W)-1:0]   evt_code,
    input  logic                       evt_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic                       err_multi
);

    import key_pkg::*;

    localparam int unsigned KC_W = $clog2(KEY_W);

    logic            push_req;
    logic            multi_req;
    logic [KC_W-1:0] push_code;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop_now;
    logic            drop;

    // Classify this cycle's key input.
    always_comb begin
        push_req  = is_onehot(key_val);
        multi_req = (|key_val) && !push_req;
        push_code = onehot_to_code(key_val);
    end

    assign pop_now   = evt_ready && !fifo_empty;
    assign drop      = push_req && fifo_full && !pop_now;
    assign evt_valid = !fifo_empty;

    sync_fifo #(
        .WIDTH (KC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (evt_ready),
        .din   (push_code),
        .dout  (evt_code),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sticky overflow (a new drop beats a clear) and one-cycle multi-hot flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            err_multi <= 1'b0;
        end else begin
            err_multi <= multi_req;
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
